bird_motion: RTL
================

Name: bird_motion

Overview:
- Parametrised successor to the single-column bird position FSM.
- Tracks the bird's vertical row with velocity and gravity rather than fixed ±1 steps.
- Detects flap edges, and adds a wait-to-start state, a pause input, sticky loss and a synchronous restart.
- Sits between the debounced flap key and the LED-matrix/collision logic; drives the bird column and the game-over flag.

Parameters:
- ROWS, 8, number of vertical positions (≥4).
- TICK_CYCLES, 192, clk cycles per motion tick (≥2).
- START_ROW, 4, row loaded on reset/restart (<ROWS).
- FLAP_VEL, 2, upward velocity set by a flap (≥1).
- MAX_FALL, 2, maximum downward speed, magnitude (≥1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  run enable; 0 pauses everything except the flap edge latch.
- restart  in  1  synchronous return to READY.
- flap  in  1  level flap key; only rising edges count.
- pos_onehot  out  ROWS  one-hot bird row (bit 0 = floor).
- pos_row  out  $clog2(ROWS)  binary bird row.
- vel  out  VEL_W signed  current velocity. VEL_W = $clog2(max(FLAP_VEL,MAX_FALL)+1)+1.
- tick  out  1  one-cycle pulse on each motion tick.
- lose  out  1  sticky game-over flag.

Behaviour:
- Async reset values:
  - state=READY, pos_row=START_ROW, vel=0, prescaler=0.
  - pending=0, flap_q=0, tick=0, lose=0.
- Outputs derived from registers:
  - pos_onehot = 1<<pos_row, combinational from the pos_row register, so there is no extra latency.
- Edge detect:
  - flap_q <= flap every cycle.
  - flap_edge = flap & ~flap_q.
  - pending <= pending | flap_edge. Edges between ticks are never lost; multiple edges collapse into one.
- States:
  - READY:
    - Prescaler held at 0, tick=0, bird held.
    - On flap_edge (with en=1) → FLY; pending set, prescaler restarts at 0.
  - FLY:
    - Prescaler counts 0..TICK_CYCLES-1 while en=1.
    - tick=1 for the cycle where prescaler==TICK_CYCLES-1 and en=1; prescaler then wraps to 0.
  - DEAD:
    - Everything frozen, lose=1.
    - Exits only on restart or reset.
- On tick, all updates are registered together:
  - eff_flap = pending | flap_edge; a same-cycle edge counts.
  - v' = eff_flap ? +FLAP_VEL : max(vel-1, -MAX_FALL).
  - r = pos_row + v', computed in signed $clog2(ROWS)+VEL_W+1 bits.
  - If r<0: pos_row=0, vel=0, lose=1, state=DEAD.
  - Else if r>ROWS-1: pos_row=ROWS-1, vel=0 (ceiling clamp, not fatal).
  - Else: pos_row=r, vel=v'.
  - pending cleared, unless flap_edge occurs in the cycle after the tick.
- Landing exactly on row 0 is not a loss; only an attempted move below 0 is.
- en=0: prescaler, tick and state frozen; pending still accumulates.
- restart=1:
  - Next edge loads all reset values and state=READY.
  - Overrides a simultaneous tick or flap_edge.
  - flap_q still samples flap.
- Reset mid-operation: immediate asynchronous return to reset values from any state.

Decomposition:
- Package bird_pkg holds:
  - typedef enum logic [1:0] {READY, FLY, DEAD} bird_state_t;
  - localparam function for VEL_W.
  - shared ROWS default constant used by the matrix driver.
- Sub-module tick_prescaler(clk, reset, clr, en, tick):
  - Parametrised by TICK_CYCLES.
  - clr asserted in READY/DEAD and on restart.

Test Plan (bench uses TICK_CYCLES=4, other parameters at defaults):
- Reset, then idle 20 cycles → pos_row=4, pos_onehot=8'b0001_0000, vel=0, lose=0, tick never asserted.
- One flap pulse, then no flaps → rows per tick 6,7,7,6,4,2,0. Tick 8 gives lose=1, pos_row=0. State DEAD; no further ticks.
- Hold flap high for 40 cycles after start → only the first tick sees a flap (row 6). Then gravity applies as above, proving edge-only detection.
- Flap edge on every tick from row 6 → row 7 with vel=0 each tick; lose stays 0.
- Drop en for 10 cycles mid-flight with a flap edge inside → no ticks and row unchanged while paused. First tick after en=1 applies vel=+2.
- restart while DEAD, and reset asserted mid-cycle during FLY → pos_row=4, lose=0, state READY. Async reset clears outputs before the next clk edge.

Source files
------------

// File: rtl/bird_pkg.sv
// rtl/bird_pkg.sv - shared types and sizing helpers for the bird motion block
package bird_pkg;

  typedef enum logic [1:0] {READY, FLY, DEAD} bird_state_t;

  // Row count also used by the LED-matrix driver
  localparam int DEFAULT_ROWS = 8;

  function automatic int clog2_int(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Signed width that holds +FLAP_VEL and one step below -MAX_FALL
  function automatic int vel_width(input int flap_vel, input int max_fall);
    int mx;
    mx = (flap_vel > max_fall) ? flap_vel : max_fall;
    return clog2_int(mx + 1) + 1;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - motion tick divider with clear and pause
module tick_prescaler #(
  parameter int TICK_CYCLES = 192
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Tick is the last count of the period; never while cleared or paused
  assign tick = en & ~clr & (cnt == LAST);

  // Count 0..TICK_CYCLES-1 while enabled, held at zero while cleared
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bird_motion.sv
// rtl/bird_motion.sv - bird row tracking with flap velocity, gravity and loss detection
module bird_motion
  import bird_pkg::*;
#(
  parameter int ROWS        = DEFAULT_ROWS,
  parameter int TICK_CYCLES = 192,
  parameter int START_ROW   = 4,
  parameter int FLAP_VEL    = 2,
  parameter int MAX_FALL    = 2,
  localparam int VEL_W      = vel_width(FLAP_VEL, MAX_FALL)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     restart,
  input  logic                     flap,
  output logic [ROWS-1:0]          pos_onehot,
  output logic [$clog2(ROWS)-1:0]  pos_row,
  output logic signed [VEL_W-1:0]  vel,
  output logic                     tick,
  output logic                     lose
);

  localparam int PW = $clog2(ROWS);
  localparam int W  = PW + VEL_W + 1;
  localparam logic signed [W-1:0] FLAP_W    = W'(FLAP_VEL);
  localparam logic signed [W-1:0] FALL_W    = W'(-MAX_FALL);
  localparam logic signed [W-1:0] ONE_W     = W'(1);
  localparam logic signed [W-1:0] ROW_MAX_W = W'(ROWS - 1);

  bird_state_t state;
  logic        flap_q;
  logic        pending;
  logic        flap_edge;
  logic        eff_flap;
  logic        clr;

  logic signed [W-1:0] vel_w, pos_w, dec_w, vnext_w, r_w;

  assign flap_edge  = flap & ~flap_q;
  assign eff_flap   = pending | flap_edge;
  assign clr        = (state != FLY) | restart;
  assign pos_onehot = {{(ROWS-1){1'b0}}, 1'b1} << pos_row;

  tick_prescaler #(
    .TICK_CYCLES (TICK_CYCLES)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .en    (en),
    .tick  (tick)
  );

  // Next velocity and candidate row, evaluated wide and signed to catch under/overflow
  always_comb begin
    vel_w   = {{(W-VEL_W){vel[VEL_W-1]}}, vel};
    pos_w   = {{(W-PW){1'b0}}, pos_row};
    dec_w   = vel_w - ONE_W;
    vnext_w = eff_flap ? FLAP_W : ((dec_w < FALL_W) ? FALL_W : dec_w);
    r_w     = pos_w + vnext_w;
  end

  // Game state, position, velocity and flap bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= READY;
      pos_row <= PW'(START_ROW);
      vel     <= '0;
      pending <= 1'b0;
      flap_q  <= 1'b0;
      lose    <= 1'b0;
    end else begin
      flap_q <= flap;
      if (restart) begin
        state   <= READY;
        pos_row <= PW'(START_ROW);
        vel     <= '0;
        pending <= 1'b0;
        lose    <= 1'b0;
      end else begin
        case (state)
          READY: begin
            pending <= pending | flap_edge;
            if (flap_edge && en) state <= FLY;
          end
          FLY: begin
            if (tick) begin
              pending <= 1'b0;
              if (r_w[W-1]) begin
                pos_row <= '0;
                vel     <= '0;
                lose    <= 1'b1;
                state   <= DEAD;
              end else if (r_w > ROW_MAX_W) begin
                pos_row <= PW'(ROWS - 1);
                vel     <= '0;
              end else begin
                pos_row <= r_w[PW-1:0];
                vel     <= vnext_w[VEL_W-1:0];
              end
            end else begin
              pending <= pending | flap_edge;
            end
          end
          default: begin
            lose <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
